// File: rtl/rename_unit.sv
// rename_unit: register renaming with speculative and retirement RATs
// plus a circular free list that is recovered on flush.
module rename_unit #(
    parameter int WIDTH        = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int NUM_ARCH     = 32,
    parameter int NUM_PHYS     = 64,
    localparam int AW          = $clog2(NUM_ARCH),
    localparam int PW          = $clog2(NUM_PHYS),
    localparam int FL_DEPTH    = NUM_PHYS - NUM_ARCH,
    localparam int CW          = $clog2(FL_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           lane_valid,
    input  logic [WIDTH*AW-1:0]        rs1,
    input  logic [WIDTH*AW-1:0]        rs2,
    input  logic [WIDTH*AW-1:0]        rd,
    input  logic [WIDTH-1:0]           rd_we,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_lane_valid,
    output logic [WIDTH*PW-1:0]        p_rs1,
    output logic [WIDTH*PW-1:0]        p_rs2,
    output logic [WIDTH*PW-1:0]        p_rd,
    output logic [WIDTH*PW-1:0]        p_old_rd,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid,
    input  logic [COMMIT_WIDTH*AW-1:0] commit_rd,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_p_rd,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_p_old_rd,
    input  logic                       flush,
    output logic [CW-1:0]              free_count,
    output logic                       err
);

    localparam int FPW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    logic [PW-1:0]  spec_rat [NUM_ARCH];
    logic [PW-1:0]  ret_rat  [NUM_ARCH];
    logic [PW-1:0]  ret_nxt  [NUM_ARCH];
    logic [PW-1:0]  fl       [FL_DEPTH];
    logic [FPW-1:0] head, tail, retire_head;
    logic [FPW-1:0] head_nxt, tail_nxt, rh_nxt;
    logic [CW-1:0]  free_count_q, ret_count;
    logic [CW-1:0]  free_nxt, ret_cnt_nxt, n_alloc;
    logic           out_valid_q, err_q, accept, err_set;

    logic [AW-1:0]  a_rd  [WIDTH];
    logic [AW-1:0]  a_rs1 [WIDTH];
    logic [AW-1:0]  a_rs2 [WIDTH];
    logic [PW-1:0]  r_rs1 [WIDTH];
    logic [PW-1:0]  r_rs2 [WIDTH];
    logic [PW-1:0]  r_rd  [WIDTH];
    logic [PW-1:0]  r_old [WIDTH];
    logic [WIDTH-1:0] alloc;

    logic [COMMIT_WIDTH-1:0] push_en;
    logic [FPW-1:0] push_idx [COMMIT_WIDTH];
    logic [PW-1:0]  push_val [COMMIT_WIDTH];
    logic [AW-1:0]  c_rd;
    logic [PW-1:0]  c_new, c_old;
    int             occ, n_push, n_adv;

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        if (p == FPW'(FL_DEPTH - 1)) return '0;
        return p + FPW'(1);
    endfunction

    // Intra-group bypass: later lanes see tags allocated by earlier lanes.
    always_comb begin
        n_alloc  = '0;
        head_nxt = head;
        for (int j = 0; j < WIDTH; j++) begin
            a_rd[j]  = rd[j*AW +: AW];
            a_rs1[j] = rs1[j*AW +: AW];
            a_rs2[j] = rs2[j*AW +: AW];
            alloc[j] = lane_valid[j] && rd_we[j] && (a_rd[j] != '0);
            r_rd[j]  = alloc[j] ? fl[head_nxt] : '0;
            if (alloc[j]) begin
                head_nxt = ptr_inc(head_nxt);
                n_alloc  = n_alloc + CW'(1);
            end
            r_rs1[j] = (a_rs1[j] == '0) ? '0 : spec_rat[a_rs1[j]];
            r_rs2[j] = (a_rs2[j] == '0) ? '0 : spec_rat[a_rs2[j]];
            r_old[j] = spec_rat[a_rd[j]];
            for (int i = 0; i < j; i++) begin
                if (alloc[i] && a_rd[i] == a_rs1[j]) r_rs1[j] = r_rd[i];
                if (alloc[i] && a_rd[i] == a_rs2[j]) r_rs2[j] = r_rd[i];
                if (alloc[i] && a_rd[i] == a_rd[j])  r_old[j] = r_rd[i];
            end
            if (!alloc[j]) r_old[j] = '0;
        end
    end

    assign in_ready = !flush && (free_count_q >= CW'(WIDTH)) &&
                      (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        ret_nxt  = ret_rat;
        tail_nxt = tail;
        rh_nxt   = retire_head;
        push_en  = '0;
        err_set  = 1'b0;
        c_rd     = '0;
        c_new    = '0;
        c_old    = '0;
        n_push   = 0;
        n_adv    = 0;
        occ      = int'(free_count_q) - (accept ? int'(n_alloc) : 0);
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            push_idx[k] = '0;
            push_val[k] = '0;
            c_rd  = commit_rd[k*AW +: AW];
            c_new = commit_p_rd[k*PW +: PW];
            c_old = commit_p_old_rd[k*PW +: PW];
            if (commit_valid[k] && c_rd != '0) begin
                if (c_old != '0) begin
                    if (occ >= FL_DEPTH) begin
                        err_set = 1'b1;
                    end else begin
                        push_en[k]  = 1'b1;
                        push_idx[k] = tail_nxt;
                        push_val[k] = c_old;
                        tail_nxt    = ptr_inc(tail_nxt);
                        occ         = occ + 1;
                        n_push      = n_push + 1;
                    end
                end
                ret_nxt[c_rd] = c_new;
                rh_nxt        = ptr_inc(rh_nxt);
                n_adv         = n_adv + 1;
            end
        end
        free_nxt    = CW'(occ);
        ret_cnt_nxt = CW'(int'(ret_count) - n_adv + n_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                spec_rat[i] <= PW'(i);
                ret_rat[i]  <= PW'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PW'(NUM_ARCH + i);
            head           <= '0;
            tail           <= '0;
            retire_head    <= '0;
            free_count_q   <= CW'(FL_DEPTH);
            ret_count      <= CW'(FL_DEPTH);
            out_valid_q    <= 1'b0;
            err_q          <= 1'b0;
            out_lane_valid <= '0;
            p_rs1          <= '0;
            p_rs2          <= '0;
            p_rd           <= '0;
            p_old_rd       <= '0;
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (push_en[k]) fl[push_idx[k]] <= push_val[k];
            ret_rat     <= ret_nxt;
            tail        <= tail_nxt;
            retire_head <= rh_nxt;
            ret_count   <= ret_cnt_nxt;
            if (err_set) err_q <= 1'b1;
            if (flush) begin
                // Roll back to the committed view, commits of this cycle included.
                spec_rat     <= ret_nxt;
                head         <= rh_nxt;
                free_count_q <= ret_cnt_nxt;
                out_valid_q  <= 1'b0;
            end else begin
                free_count_q <= free_nxt;
                if (accept) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (alloc[j]) spec_rat[a_rd[j]] <= r_rd[j];
                        p_rs1[j*PW +: PW]    <= r_rs1[j];
                        p_rs2[j*PW +: PW]    <= r_rs2[j];
                        p_rd[j*PW +: PW]     <= r_rd[j];
                        p_old_rd[j*PW +: PW] <= r_old[j];
                    end
                    head           <= head_nxt;
                    out_lane_valid <= lane_valid;
                    out_valid_q    <= 1'b1;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign free_count = free_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed vectors with hand-computed tags
// for the default two-lane rename_unit.
module tb_rename_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  lane_valid;
    logic [9:0]  rs1, rs2, rd;
    logic [1:0]  rd_we;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane_valid;
    logic [11:0] p_rs1, p_rs2, p_rd, p_old_rd;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd;
    logic [11:0] commit_p_rd, commit_p_old_rd;
    logic        flush;
    logic [5:0]  free_count;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    rename_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .lane_valid(lane_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd_we(rd_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid),
        .p_rs1(p_rs1), .p_rs2(p_rs2), .p_rd(p_rd), .p_old_rd(p_old_rd),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_p_rd(commit_p_rd), .commit_p_old_rd(commit_p_old_rd),
        .flush(flush), .free_count(free_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] g_rs1(input int j);
        return 32'(p_rs1[j*6 +: 6]);
    endfunction
    function automatic logic [31:0] g_rs2(input int j);
        return 32'(p_rs2[j*6 +: 6]);
    endfunction
    function automatic logic [31:0] g_rd(input int j);
        return 32'(p_rd[j*6 +: 6]);
    endfunction
    function automatic logic [31:0] g_old(input int j);
        return 32'(p_old_rd[j*6 +: 6]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid        = 1'b0;
        lane_valid      = '0;
        rd_we           = '0;
        rs1             = '0;
        rs2             = '0;
        rd              = '0;
        commit_valid    = '0;
        commit_rd       = '0;
        commit_p_rd     = '0;
        commit_p_old_rd = '0;
        flush           = 1'b0;
    endtask

    task automatic set_lane(input int j, input bit v, input bit we,
                            input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2);
        lane_valid[j]    = v;
        rd_we[j]         = we;
        rd[j*5 +: 5]     = d;
        rs1[j*5 +: 5]    = s1;
        rs2[j*5 +: 5]    = s2;
    endtask

    task automatic set_commit(input int k, input logic [4:0] a,
                              input logic [5:0] pn, input logic [5:0] po);
        commit_valid[k]          = 1'b1;
        commit_rd[k*5 +: 5]       = a;
        commit_p_rd[k*6 +: 6]     = pn;
        commit_p_old_rd[k*6 +: 6] = po;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        out_ready = 1'b1;

        // Reset state and basic group with intra-group bypass
        do_reset();
        check("rst_free", 32'(free_count), 32);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_ir", 32'(in_ready), 1);
        check("rst_err", 32'(err), 0);
        check("rst_prd", 32'(p_rd), 0);
        set_lane(0, 1, 1, 5'd1, 5'd2, 5'd3);
        set_lane(1, 1, 1, 5'd4, 5'd1, 5'd1);
        in_valid = 1'b1;
        tick();
        idle();
        check("g1_ov", 32'(out_valid), 1);
        check("g1_l0_rs1", g_rs1(0), 2);
        check("g1_l0_rs2", g_rs2(0), 3);
        check("g1_l0_rd", g_rd(0), 32);
        check("g1_l0_old", g_old(0), 1);
        check("g1_l1_rs1", g_rs1(1), 32);
        check("g1_l1_rs2", g_rs2(1), 32);
        check("g1_l1_rd", g_rd(1), 33);
        check("g1_l1_old", g_old(1), 4);
        check("g1_free", 32'(free_count), 30);
        check("g1_olv", 32'(out_lane_valid), 3);

        // Same rd in both lanes, then a reader of that rd
        do_reset();
        check("rst2_ov", 32'(out_valid), 0);
        set_lane(0, 1, 1, 5'd5, 5'd0, 5'd0);
        set_lane(1, 1, 1, 5'd5, 5'd0, 5'd0);
        in_valid = 1'b1;
        tick();
        check("g2_l0_rd", g_rd(0), 32);
        check("g2_l0_old", g_old(0), 5);
        check("g2_l1_rd", g_rd(1), 33);
        check("g2_l1_old", g_old(1), 32);
        idle();
        set_lane(0, 1, 0, 5'd0, 5'd5, 5'd0);
        in_valid = 1'b1;
        tick();
        idle();
        check("g3_rs1", g_rs1(0), 33);
        check("g3_rd0", g_rd(0), 0);
        check("g3_old0", g_old(0), 0);
        check("g3_rd1", g_rd(1), 0);
        check("g3_free", 32'(free_count), 30);

        // Back-pressure: group then three stalled cycles
        set_lane(0, 1, 1, 5'd7, 5'd5, 5'd0);
        set_lane(1, 1, 1, 5'd0, 5'd0, 5'd7);
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        set_lane(0, 1, 1, 5'd8, 5'd1, 5'd1);
        set_lane(1, 1, 1, 5'd9, 5'd1, 5'd1);
        #1;
        check("stall_ir", 32'(in_ready), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_ov", 32'(out_valid), 1);
            check("stall_rs1", g_rs1(0), 33);
            check("stall_rd", g_rd(0), 34);
            check("stall_old", g_old(0), 7);
            check("stall_l1rd", g_rd(1), 0);
            check("stall_l1rs2", g_rs2(1), 34);
            check("stall_free", 32'(free_count), 29);
        end
        idle();
        out_ready = 1'b1;
        tick();
        check("drain_ov", 32'(out_valid), 0);

        // Exhaust the free list, then free one tag at a time
        do_reset();
        set_lane(0, 1, 1, 5'd1, 5'd0, 5'd0);
        set_lane(1, 1, 1, 5'd2, 5'd0, 5'd0);
        in_valid = 1'b1;
        for (int g = 0; g < 16; g++) tick();
        idle();
        #1;
        check("full_free", 32'(free_count), 0);
        check("full_ir", 32'(in_ready), 0);
        check("full_l1rd", g_rd(1), 63);
        check("full_l0old", g_old(0), 60);
        check("full_l1old", g_old(1), 61);
        set_commit(0, 5'd1, 6'd32, 6'd1);
        tick();
        idle();
        check("c1_free", 32'(free_count), 1);
        check("c1_ir", 32'(in_ready), 0);
        set_commit(0, 5'd2, 6'd33, 6'd2);
        tick();
        idle();
        check("c2_free", 32'(free_count), 2);
        check("c2_ir", 32'(in_ready), 1);
        set_lane(0, 1, 1, 5'd3, 5'd0, 5'd0);
        set_lane(1, 1, 1, 5'd9, 5'd0, 5'd0);
        in_valid = 1'b1;
        tick();
        idle();
        check("reuse_l0", g_rd(0), 1);
        check("reuse_l1", g_rd(1), 2);
        check("reuse_free", 32'(free_count), 0);

        // Flush with nothing committed
        do_reset();
        set_lane(0, 1, 1, 5'd1, 5'd0, 5'd0);
        in_valid = 1'b1;
        tick();
        idle();
        check("f1_rd", g_rd(0), 32);
        flush = 1'b1;
        set_lane(0, 1, 1, 5'd6, 5'd1, 5'd0);
        in_valid = 1'b1;
        #1;
        check("f1_ir", 32'(in_ready), 0);
        tick();
        flush = 1'b0;
        check("f1_ov", 32'(out_valid), 0);
        check("f1_free", 32'(free_count), 32);
        tick();
        idle();
        check("f1_rs1", g_rs1(0), 1);
        check("f1_rd6", g_rd(0), 32);
        check("f1_old6", g_old(0), 6);

        // Flush in the same cycle as a commit
        do_reset();
        set_lane(0, 1, 1, 5'd1, 5'd0, 5'd0);
        set_lane(1, 1, 1, 5'd2, 5'd0, 5'd0);
        in_valid = 1'b1;
        tick();
        idle();
        flush = 1'b1;
        set_commit(0, 5'd1, 6'd32, 6'd1);
        tick();
        idle();
        check("f2_free", 32'(free_count), 32);
        set_lane(0, 1, 1, 5'd3, 5'd1, 5'd2);
        in_valid = 1'b1;
        tick();
        idle();
        check("f2_rs1", g_rs1(0), 32);
        check("f2_rs2", g_rs2(0), 2);
        check("f2_rd", g_rd(0), 33);
        check("f2_old", g_old(0), 3);

        // Overflowing push is dropped and err sticks until reset
        do_reset();
        set_commit(0, 5'd1, 6'd5, 6'd40);
        tick();
        idle();
        check("ovf_err", 32'(err), 1);
        check("ovf_free", 32'(free_count), 32);
        tick();
        tick();
        check("ovf_sticky", 32'(err), 1);
        do_reset();
        check("ovf_clr", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
